// File: rtl/axis_vc_queue_pkg.sv
// Shared helpers and reference types for axis_vc_queue.
// Width helpers are functions so the parameterised top can size its own types.
package axis_vc_queue_pkg;

  localparam int DEF_NUM_VC     = 2;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_DEST_WIDTH = 4;
  localparam int DEF_USER_WIDTH = 4;

  // VC index width; a single VC still needs one bit on the ports
  function automatic int vc_w(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  // Occupancy width: must be able to hold DEPTH itself
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int half(input int depth);
    return depth / 2;
  endfunction

  localparam int CNT_W = cnt_w(DEF_DEPTH);
  localparam int HALF  = half(DEF_DEPTH);

  typedef logic [vc_w(DEF_NUM_VC)-1:0] vc_idx_t;
  typedef logic [CNT_W-1:0]            count_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [DEF_DEST_WIDTH-1:0] dest;
    logic [DEF_USER_WIDTH-1:0] user;
    logic                      last;
  } vcq_entry_t;

endpackage

// File: rtl/vcq_rr_arbiter.sv
// Packet-locked round-robin arbiter over NUM_VC request lines.
// While lock is set the grant is pinned to lock_vc, even if it has no request.
module vcq_rr_arbiter
  import axis_vc_queue_pkg::*;
#(
  parameter int NUM_VC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_VC-1:0]         req,
  input  logic                      lock,
  input  logic [vc_w(NUM_VC)-1:0]   lock_vc,
  input  logic                      advance,
  output logic [vc_w(NUM_VC)-1:0]   gnt,
  output logic                      gnt_valid
);

  localparam int          VC_W = vc_w(NUM_VC);
  localparam int unsigned N    = NUM_VC;

  logic [VC_W-1:0] ptr;
  int unsigned     idx;

  // Pick the first requester at or after ptr, unless a packet holds the lock
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    if (lock) begin
      gnt       = lock_vc;
      gnt_valid = req[lock_vc];
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        idx = 32'(ptr) + i;
        if (idx >= N) idx = idx - N;
        if (!gnt_valid && req[VC_W'(idx)]) begin
          gnt       = VC_W'(idx);
          gnt_valid = 1'b1;
        end
      end
    end
  end

  // Priority moves past every served VC; under lock this lands on locked VC+1 at tlast
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt == VC_W'(NUM_VC - 1)) ? '0 : gnt + 1'b1;
    end
  end

endmodule

// File: rtl/axis_vc_queue.sv
// Multi-VC AXI-Stream input buffer with packet-locked RR output and registered output stage.
// Optional high-water marks on peak_o are enabled by defining AXIS_VC_QUEUE_PEAK_STATS_EN.
module axis_vc_queue
  import axis_vc_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4,
  parameter int NUM_VC     = 2,
  parameter int DEPTH      = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_tvalid_i,
  output logic                           in_tready_o,
  input  logic [vc_w(NUM_VC)-1:0]        in_vc_i,
  input  logic [DATA_WIDTH-1:0]          in_tdata_i,
  input  logic [ID_WIDTH-1:0]            in_tid_i,
  input  logic [DEST_WIDTH-1:0]          in_tdest_i,
  input  logic [USER_WIDTH-1:0]          in_tuser_i,
  input  logic                           in_tlast_i,
  output logic                           out_tvalid_o,
  input  logic                           out_tready_i,
  output logic [vc_w(NUM_VC)-1:0]        out_vc_o,
  output logic [DATA_WIDTH-1:0]          out_tdata_o,
  output logic [ID_WIDTH-1:0]            out_tid_o,
  output logic [DEST_WIDTH-1:0]          out_tdest_o,
  output logic [USER_WIDTH-1:0]          out_tuser_o,
  output logic                           out_tlast_o,
  output logic [NUM_VC-1:0]              empty_o,
  output logic [NUM_VC-1:0]              half_full_o,
  output logic [NUM_VC-1:0]              full_o,
  output logic [NUM_VC*cnt_w(DEPTH)-1:0] count_o,
  output logic [NUM_VC*cnt_w(DEPTH)-1:0] peak_o,
  input  logic                           peak_clr_i
);

  localparam int VC_W     = vc_w(NUM_VC);
  localparam int CW       = cnt_w(DEPTH);
  localparam int PTR_W    = CW - 1;
  localparam int HALF_LVL = half(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  last;
  } entry_t;

  entry_t            mem [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr [NUM_VC];
  logic [CW-1:0]     count [NUM_VC];
  logic [CW-1:0]     count_next [NUM_VC];
  logic [NUM_VC-1:0] req, wr_hit, rd_hit;
  logic              vc_ok, wr_en, load_en, mv_en, gnt_valid, lock;
  logic [VC_W-1:0]   gnt, lock_vc;
  entry_t            head, out_q;

  assign vc_ok       = 32'(in_vc_i) < 32'(NUM_VC);
  assign in_tready_o = !rst_i && vc_ok && !full_o[in_vc_i];
  assign wr_en       = in_tvalid_i && in_tready_o;
  assign load_en     = !out_tvalid_o || out_tready_i;
  assign mv_en       = load_en && gnt_valid;
  assign head        = mem[gnt][rd_ptr[gnt]];

  // Per-VC flags, packed counts and next occupancy (output register is not counted)
  always_comb begin
    empty_o     = '0;
    half_full_o = '0;
    full_o      = '0;
    count_o     = '0;
    req         = '0;
    wr_hit      = '0;
    rd_hit      = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      empty_o[v]           = (count[v] == '0);
      half_full_o[v]       = (count[v] > CW'(HALF_LVL));
      full_o[v]            = (count[v] == CW'(DEPTH));
      count_o[v*CW +: CW]  = count[v];
      req[v]               = (count[v] != '0);
      wr_hit[v]            = wr_en && (in_vc_i == VC_W'(v));
      rd_hit[v]            = mv_en && (gnt == VC_W'(v));
      count_next[v]        = count[v];
      if (wr_hit[v] && !rd_hit[v])      count_next[v] = count[v] + 1'b1;
      else if (rd_hit[v] && !wr_hit[v]) count_next[v] = count[v] - 1'b1;
    end
  end

  // Storage array; reset only clears pointers, so contents need no reset
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[in_vc_i][wr_ptr[in_vc_i]] <= '{in_tdata_i, in_tid_i, in_tdest_i, in_tuser_i, in_tlast_i};
    end
  end

  // Pointer and occupancy bookkeeping per VC
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        if (wr_hit[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (rd_hit[v]) rd_ptr[v] <= rd_ptr[v] + 1'b1;
        count[v] <= count_next[v];
      end
    end
  end

  // Output register and packet lock; lock follows the tlast of the beat just loaded
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_tvalid_o <= 1'b0;
      out_q        <= '0;
      out_vc_o     <= '0;
      lock         <= 1'b0;
      lock_vc      <= '0;
    end else if (load_en) begin
      if (gnt_valid) begin
        out_tvalid_o <= 1'b1;
        out_q        <= head;
        out_vc_o     <= gnt;
        lock         <= !head.last;
        lock_vc      <= gnt;
      end else begin
        out_tvalid_o <= 1'b0;
      end
    end
  end

  assign out_tdata_o = out_q.data;
  assign out_tid_o   = out_q.id;
  assign out_tdest_o = out_q.dest;
  assign out_tuser_o = out_q.user;
  assign out_tlast_o = out_q.last;

  vcq_rr_arbiter #(
    .NUM_VC (NUM_VC)
  ) u_arb (
    .clk       (clk_i),
    .rst       (rst_i),
    .req       (req),
    .lock      (lock),
    .lock_vc   (lock_vc),
    .advance   (mv_en),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

`ifdef AXIS_VC_QUEUE_PEAK_STATS_EN
  logic [CW-1:0] peak [NUM_VC];

  // High-water marks track next-cycle occupancy; clear wins over update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned v = 0; v < NUM_VC; v++) peak[v] <= '0;
    end else if (peak_clr_i) begin
      for (int unsigned v = 0; v < NUM_VC; v++) peak[v] <= '0;
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        if (count_next[v] > peak[v]) peak[v] <= count_next[v];
      end
    end
  end

  // Pack high-water marks with VC0 in the LSBs
  always_comb begin
    peak_o = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) peak_o[v*CW +: CW] = peak[v];
  end
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr_i;
  assign peak_o          = '0;
`endif

endmodule

// File: tb/tb_axis_vc_queue.sv
// Directed bench for axis_vc_queue (NUM_VC=2, DEPTH=16): vector table plus hand sequences.
module tb_axis_vc_queue;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_tvalid, in_tready, in_tlast;
  logic [0:0]  in_vc;
  logic [31:0] in_tdata;
  logic [3:0]  in_tid, in_tdest, in_tuser;
  logic        out_tvalid, out_tready, out_tlast;
  logic [0:0]  out_vc;
  logic [31:0] out_tdata;
  logic [3:0]  out_tid, out_tdest, out_tuser;
  logic [1:0]  empty, half_full, full;
  logic [9:0]  count, peak;
  logic        peak_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vld;
    logic        vc;
    logic [31:0] data;
    logic        lst;
    logic        rdy;
    logic        e_tready;
    logic        e_ov;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_vc;
    int          e_c0;
    int          e_c1;
  } vec_t;

  vec_t tbl[$];

  axis_vc_queue #(
    .DATA_WIDTH (32),
    .ID_WIDTH   (4),
    .DEST_WIDTH (4),
    .USER_WIDTH (4),
    .NUM_VC     (2),
    .DEPTH      (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_tvalid_i  (in_tvalid),
    .in_tready_o  (in_tready),
    .in_vc_i      (in_vc),
    .in_tdata_i   (in_tdata),
    .in_tid_i     (in_tid),
    .in_tdest_i   (in_tdest),
    .in_tuser_i   (in_tuser),
    .in_tlast_i   (in_tlast),
    .out_tvalid_o (out_tvalid),
    .out_tready_i (out_tready),
    .out_vc_o     (out_vc),
    .out_tdata_o  (out_tdata),
    .out_tid_o    (out_tid),
    .out_tdest_o  (out_tdest),
    .out_tuser_o  (out_tuser),
    .out_tlast_o  (out_tlast),
    .empty_o      (empty),
    .half_full_o  (half_full),
    .full_o       (full),
    .count_o      (count),
    .peak_o       (peak),
    .peak_clr_i   (peak_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic vc, input logic [31:0] d, input logic l);
    in_tvalid = v;
    in_vc     = vc;
    in_tdata  = d;
    in_tid    = d[3:0];
    in_tdest  = d[7:4];
    in_tuser  = ~d[3:0];
    in_tlast  = l;
  endtask

  task automatic add(input logic v, input logic vc, input logic [31:0] d, input logic l,
                     input logic rdy, input logic et, input logic eov, input logic [31:0] ed,
                     input logic el, input logic evc, input int c0, input int c1);
    vec_t r;
    r.vld = v; r.vc = vc; r.data = d; r.lst = l; r.rdy = rdy;
    r.e_tready = et; r.e_ov = eov; r.e_data = ed; r.e_last = el; r.e_vc = evc;
    r.e_c0 = c0; r.e_c1 = c1;
    tbl.push_back(r);
  endtask

  task automatic run_rows(input int first, input int lst);
    vec_t r;
    for (int i = first; i <= lst; i++) begin
      r = tbl[i];
      drive(r.vld, r.vc, r.data, r.lst);
      out_tready = r.rdy;
      @(negedge clk);
      chk($sformatf("row%0d tready", i), 32'(in_tready), 32'(r.e_tready));
      chk($sformatf("row%0d tvalid", i), 32'(out_tvalid), 32'(r.e_ov));
      chk($sformatf("row%0d count0", i), 32'(count[4:0]), 32'(r.e_c0));
      chk($sformatf("row%0d count1", i), 32'(count[9:5]), 32'(r.e_c1));
      chk($sformatf("row%0d empty", i), 32'(empty), {30'd0, r.e_c1 == 0, r.e_c0 == 0});
      if (r.e_ov) begin
        chk($sformatf("row%0d tdata", i), out_tdata, r.e_data);
        chk($sformatf("row%0d tlast", i), 32'(out_tlast), 32'(r.e_last));
        chk($sformatf("row%0d vc", i), 32'(out_vc), 32'(r.e_vc));
        chk($sformatf("row%0d sideband", i), {20'd0, out_tid, out_tdest, out_tuser},
            {20'd0, r.e_data[3:0], r.e_data[7:4], ~r.e_data[3:0]});
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; peak_clr = 1'b0; out_tready = 1'b0;
    drive(N, N, 32'h0, N);

    // rows 0-5: 3-beat packet on VC0, downstream always ready
    add(Y, N, 32'hA1, N, Y,  Y, N, 32'h0,  N, N, 0, 0);
    add(Y, N, 32'hA2, N, Y,  Y, N, 32'h0,  N, N, 1, 0);
    add(Y, N, 32'hA3, Y, Y,  Y, Y, 32'hA1, N, N, 1, 0);
    add(N, N, 32'h0,  N, Y,  Y, Y, 32'hA2, N, N, 1, 0);
    add(N, N, 32'h0,  N, Y,  Y, Y, 32'hA3, Y, N, 0, 0);
    add(N, N, 32'h0,  N, Y,  Y, N, 32'h0,  N, N, 0, 0);
    // rows 6-14: 2-beat packets on VC0 and VC1, VC0 packet must finish first
    add(Y, N, 32'hC0, N, N,  Y, N, 32'h0,  N, N, 0, 0);
    add(Y, Y, 32'hD0, N, N,  Y, N, 32'h0,  N, N, 1, 0);
    add(Y, N, 32'hC1, Y, N,  Y, Y, 32'hC0, N, N, 0, 1);
    add(Y, Y, 32'hD1, Y, N,  Y, Y, 32'hC0, N, N, 1, 1);
    add(N, N, 32'h0,  N, Y,  Y, Y, 32'hC0, N, N, 1, 2);
    add(N, N, 32'h0,  N, Y,  Y, Y, 32'hC1, Y, N, 0, 2);
    add(N, N, 32'h0,  N, Y,  Y, Y, 32'hD0, N, Y, 0, 1);
    add(N, N, 32'h0,  N, Y,  Y, Y, 32'hD1, Y, Y, 0, 0);
    add(N, N, 32'h0,  N, Y,  Y, N, 32'h0,  N, N, 0, 0);
    // rows 15-23: lock on empty VC1 bubbles while VC0 waits
    add(Y, Y, 32'hE0, N, Y,  Y, N, 32'h0,  N, N, 0, 0);
    add(Y, N, 32'hF0, Y, Y,  Y, N, 32'h0,  N, N, 0, 1);
    add(N, N, 32'h0,  N, Y,  Y, Y, 32'hE0, N, Y, 1, 0);
    add(N, N, 32'h0,  N, Y,  Y, N, 32'h0,  N, N, 1, 0);
    add(Y, Y, 32'hE1, Y, Y,  Y, N, 32'h0,  N, N, 1, 0);
    add(N, N, 32'h0,  N, Y,  Y, N, 32'h0,  N, N, 1, 1);
    add(N, N, 32'h0,  N, Y,  Y, Y, 32'hE1, Y, Y, 1, 0);
    add(N, N, 32'h0,  N, Y,  Y, Y, 32'hF0, Y, N, 0, 0);
    add(N, N, 32'h0,  N, Y,  Y, N, 32'h0,  N, N, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst tready", 32'(in_tready), 32'd0);
    chk("rst tvalid", 32'(out_tvalid), 32'd0);
    chk("rst empty", 32'(empty), 32'd3);
    chk("rst half_full", 32'(half_full), 32'd0);
    chk("rst full", 32'(full), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst outs", {out_tdata[27:0], out_tlast, out_vc, 2'b00}, 32'd0);
    chk("rst peak", 32'(peak), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_rows(0, 5);

    // fill VC1 behind a held output beat
    out_tready = 1'b0;
    drive(Y, N, 32'h55, Y);
    @(negedge clk);
    chk("fill pre tready", 32'(in_tready), 32'd1);
    @(posedge clk); #1;
    drive(N, N, 32'h0, N);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fill held valid", 32'(out_tvalid), 32'd1);
    chk("fill held data", out_tdata, 32'h55);
    chk("fill count0", 32'(count[4:0]), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      drive(Y, Y, 32'h100 + 32'(i), i[0]);
      @(negedge clk);
      chk($sformatf("fill%0d tready", i), 32'(in_tready), 32'd1);
      chk($sformatf("fill%0d count1", i), 32'(count[9:5]), 32'(i));
      chk($sformatf("fill%0d half", i), 32'(half_full[1]), 32'(i > 8));
      chk($sformatf("fill%0d full", i), 32'(full[1]), 32'd0);
      @(posedge clk); #1;
    end
    drive(N, Y, 32'h0, N);
    @(negedge clk);
    chk("full count1", 32'(count[9:5]), 32'd16);
    chk("full flag", 32'(full), 32'd2);
    chk("full half", 32'(half_full), 32'd2);
    chk("full tready vc1", 32'(in_tready), 32'd0);
    in_vc = 1'b0;
    #1;
    chk("full tready vc0", 32'(in_tready), 32'd1);
    drive(Y, Y, 32'h1EE, Y);
    @(posedge clk); #1;
    drive(N, Y, 32'h0, N);
    @(negedge clk);
    chk("17th refused", 32'(count[9:5]), 32'd16);
    chk("stall data", out_tdata, 32'h55);
    chk("stall vc", 32'(out_vc), 32'd0);

    // full VC drained and written in the same cycle
    @(posedge clk); #1;
    out_tready = 1'b1;
    drive(Y, Y, 32'h1FF, Y);
    @(negedge clk);
    chk("drain tready", 32'(in_tready), 32'd0);
    @(posedge clk); #1;
    out_tready = 1'b0;
    @(negedge clk);
    chk("drain count1", 32'(count[9:5]), 32'd15);
    chk("drain data", out_tdata, 32'h100);
    chk("drain vc", 32'(out_vc), 32'd1);
    chk("drain tready", 32'(in_tready), 32'd1);
    @(posedge clk); #1;
    drive(N, N, 32'h0, N);
    @(negedge clk);
    chk("refill count1", 32'(count[9:5]), 32'd16);
    @(posedge clk); #1;
    out_tready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      chk($sformatf("out%0d valid", k), 32'(out_tvalid), 32'd1);
      chk($sformatf("out%0d data", k), out_tdata, (k == 16) ? 32'h1FF : 32'h100 + 32'(k));
      chk($sformatf("out%0d last", k), 32'(out_tlast), (k == 16) ? 32'd1 : 32'(k % 2));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drained valid", 32'(out_tvalid), 32'd0);
    chk("drained empty", 32'(empty), 32'd3);
    @(posedge clk); #1;

    run_rows(6, 23);

    // high-water marks, then reset mid-packet
`ifdef AXIS_VC_QUEUE_PEAK_STATS_EN
    @(negedge clk);
    chk("peak vc1", 32'(peak[9:5]), 32'd16);
    @(posedge clk); #1;
`endif
    peak_clr = 1'b1;
    @(posedge clk); #1;
    peak_clr = 1'b0;
    @(negedge clk);
    chk("peak cleared", 32'(peak), 32'd0);
    @(posedge clk); #1;
    out_tready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      drive(Y, N, 32'hC0 + 32'(j), N);
      @(posedge clk); #1;
    end
    drive(N, N, 32'h0, N);
    @(negedge clk);
    chk("mid count0", 32'(count[4:0]), 32'd5);
    chk("mid data", out_tdata, 32'hC0);
`ifdef AXIS_VC_QUEUE_PEAK_STATS_EN
    chk("mid peak0", 32'(peak[4:0]), 32'd5);
`else
    chk("mid peak", 32'(peak), 32'd0);
`endif
    rst = 1'b1;
    #1;
    chk("async count", 32'(count), 32'd0);
    chk("async empty", 32'(empty), 32'd3);
    chk("async valid", 32'(out_tvalid), 32'd0);
    chk("async data", out_tdata, 32'd0);
    chk("async tready", 32'(in_tready), 32'd0);
    @(posedge clk); #1;
    chk("post rst count", 32'(count), 32'd0);
    chk("post rst valid", 32'(out_tvalid), 32'd0);
    chk("post rst peak", 32'(peak), 32'd0);
    rst = 1'b0;
    out_tready = 1'b1;
    drive(Y, Y, 32'hD1, Y);
    @(negedge clk);
    chk("restart tready", 32'(in_tready), 32'd1);
    @(posedge clk); #1;
    drive(N, N, 32'h0, N);
    @(posedge clk); #1;
    @(negedge clk);
    chk("restart valid", 32'(out_tvalid), 32'd1);
    chk("restart data", out_tdata, 32'hD1);
    chk("restart vc", 32'(out_vc), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
